// File: rtl/fp_accumulator_if.sv
// Term/result handshake bundle for the floating-point group accumulator.
// master: the upstream producer plus downstream consumer (the environment).
// slave : the accumulator itself.
interface fp_accumulator_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fp_accumulator.sv
// Multi-cycle IEEE-754 single-precision group accumulator.
// One term is folded into acc every five cycles through the
// IDLE -> ALIGN -> ADD -> NORM -> ROUND sequence; a term flagged last
// parks the finished sum in OUT until the consumer takes it.
// Denormals are flushed to zero; rounding is nearest, ties to even.
module fp_accumulator (
  input  logic           clk,
  input  logic           rst,
  fp_accumulator_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_ROUND = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // ---------------------------------------------------------------------
  // Control state and handshakes
  // ---------------------------------------------------------------------
  logic [2:0]  state_q, state_d;
  logic        rdy_q;            // low while in reset, high from the first edge after
  logic [31:0] acc_q, acc_d;
  logic [31:0] term_q;
  logic        last_q;
  logic        take;
  logic        out_fire;
  logic [31:0] round_res;

  assign bus.in_ready  = rdy_q && (state_q == S_IDLE);
  assign take          = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.out_data  = (state_q == S_OUT) ? acc_q : 32'h0;
  assign out_fire      = bus.out_valid && bus.out_ready;

  // Next-state selection for the accumulate sequence.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (take) state_d = S_ALIGN;
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  state_d = S_ROUND;
      S_ROUND: state_d = last_q ? S_OUT : S_IDLE;
      S_OUT:   if (out_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Accumulator update: load the rounded sum, clear once a group is handed off.
  always_comb begin
    acc_d = acc_q;
    if (state_q == S_ROUND) acc_d = round_res;
    else if (out_fire)      acc_d = 32'h0;
  end

  // Control registers, term capture and accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      acc_q   <= 32'h0;
      term_q  <= 32'h0;
      last_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      rdy_q   <= 1'b1;
      acc_q   <= acc_d;
      if (take) begin
        term_q <= bus.in_data;
        last_q <= bus.in_last;
      end
    end
  end

  // ---------------------------------------------------------------------
  // ALIGN: unpack, classify, order by magnitude, shift the smaller operand
  // ---------------------------------------------------------------------
  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [22:0] ma, mb;
  assign {sa, ea, ma} = acc_q;
  assign {sb, eb, mb} = term_q;

  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [23:0] sig_a, sig_b;
  logic        a_ge_b;
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign a_inf  = (ea == 8'hFF) && (ma == 23'h0);
  assign b_inf  = (eb == 8'hFF) && (mb == 23'h0);
  assign a_nan  = (ea == 8'hFF) && (ma != 23'h0);
  assign b_nan  = (eb == 8'hFF) && (mb != 23'h0);
  assign sig_a  = a_zero ? 24'h0 : {1'b1, ma};
  assign sig_b  = b_zero ? 24'h0 : {1'b1, mb};
  assign a_ge_b = {ea, sig_a} >= {eb, sig_b};

  logic        big_sign_w;
  logic [7:0]  big_exp_w, small_exp_w, diff_w;
  logic [23:0] big_sig_w, small_sig_w;
  logic [26:0] small_ext_w, small_sh_w, lost_mask_w;
  assign big_sign_w  = a_ge_b ? sa : sb;
  assign big_exp_w   = a_ge_b ? ea : eb;
  assign small_exp_w = a_ge_b ? eb : ea;
  assign big_sig_w   = a_ge_b ? sig_a : sig_b;
  assign small_sig_w = a_ge_b ? sig_b : sig_a;
  assign diff_w      = big_exp_w - small_exp_w;
  assign small_ext_w = {small_sig_w, 3'b000};

  // Right-shift the smaller significand, folding every lost bit into sticky.
  always_comb begin
    lost_mask_w   = (27'd1 << diff_w[4:0]) - 27'd1;
    small_sh_w    = small_ext_w >> diff_w[4:0];
    small_sh_w[0] = small_sh_w[0] | (|(small_ext_w & lost_mask_w));
    if (diff_w >= 8'd26) small_sh_w = {26'h0, |small_sig_w};
  end

  // Special operands bypass the arithmetic and force the result.
  logic        spec_w;
  logic [31:0] spec_val_w;
  always_comb begin
    spec_w     = 1'b0;
    spec_val_w = 32'h0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      spec_w     = 1'b1;
      spec_val_w = QNAN;
    end else if (a_inf) begin
      spec_w     = 1'b1;
      spec_val_w = {sa, 8'hFF, 23'h0};
    end else if (b_inf) begin
      spec_w     = 1'b1;
      spec_val_w = {sb, 8'hFF, 23'h0};
    end else if (a_zero && b_zero) begin
      spec_w     = 1'b1;
      spec_val_w = {sa & sb, 31'h0};
    end
  end

  logic        al_sign_q, al_sub_q, al_spec_q;
  logic [7:0]  al_exp_q;
  logic [26:0] al_big_q, al_small_q;
  logic [31:0] al_spec_val_q;

  // ALIGN stage register; held until the next term reaches ALIGN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      al_sign_q     <= 1'b0;
      al_sub_q      <= 1'b0;
      al_spec_q     <= 1'b0;
      al_exp_q      <= 8'h0;
      al_big_q      <= 27'h0;
      al_small_q    <= 27'h0;
      al_spec_val_q <= 32'h0;
    end else if (state_q == S_ALIGN) begin
      al_sign_q     <= big_sign_w;
      al_sub_q      <= sa ^ sb;
      al_spec_q     <= spec_w;
      al_exp_q      <= big_exp_w;
      al_big_q      <= {big_sig_w, 3'b000};
      al_small_q    <= small_sh_w;
      al_spec_val_q <= spec_val_w;
    end
  end

  // ---------------------------------------------------------------------
  // ADD: magnitude add or subtract (larger minus smaller, never negative)
  // ---------------------------------------------------------------------
  logic [27:0] ad_sum_q;

  // ADD stage register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ad_sum_q <= 28'h0;
    end else if (state_q == S_ADD) begin
      ad_sum_q <= al_sub_q ? ({1'b0, al_big_q} - {1'b0, al_small_q})
                           : ({1'b0, al_big_q} + {1'b0, al_small_q});
    end
  end

  // ---------------------------------------------------------------------
  // NORM: fix a carry-out or strip leading zeros
  // ---------------------------------------------------------------------
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lzc27 = 5'(26 - i);
    end
  endfunction

  logic [4:0]        lz_w;
  logic [26:0]       nm_sig_d, nm_sig_q;
  logic signed [9:0] nm_exp_d, nm_exp_q;
  logic              nm_zero_d, nm_zero_q;

  // Normalise the raw sum so bit 26 holds the hidden one.
  always_comb begin
    lz_w      = lzc27(ad_sum_q[26:0]);
    nm_zero_d = (ad_sum_q == 28'h0);
    nm_sig_d  = ad_sum_q[26:0] << lz_w;
    nm_exp_d  = $signed({2'b00, al_exp_q}) - $signed({5'b00000, lz_w});
    if (ad_sum_q[27]) begin
      nm_sig_d = {ad_sum_q[27:2], ad_sum_q[1] | ad_sum_q[0]};
      nm_exp_d = $signed({2'b00, al_exp_q}) + 10'sd1;
    end
  end

  // NORM stage register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nm_sig_q  <= 27'h0;
      nm_exp_q  <= 10'sd0;
      nm_zero_q <= 1'b0;
    end else if (state_q == S_NORM) begin
      nm_sig_q  <= nm_sig_d;
      nm_exp_q  <= nm_exp_d;
      nm_zero_q <= nm_zero_d;
    end
  end

  // ---------------------------------------------------------------------
  // ROUND: nearest-even, then range checks and packing
  // ---------------------------------------------------------------------
  logic [23:0]       rn_mant_w;
  logic              rn_up_w;
  logic [24:0]       rn_sum_w;
  logic signed [9:0] rn_exp_w;
  logic [22:0]       rn_frac_w;

  assign rn_mant_w = nm_sig_q[26:3];
  assign rn_up_w   = nm_sig_q[2] & (nm_sig_q[1] | nm_sig_q[0] | rn_mant_w[0]);
  assign rn_sum_w  = {1'b0, rn_mant_w} + {24'h0, rn_up_w};

  // Round, renormalise on carry, and select the packed result.
  always_comb begin
    rn_exp_w  = nm_exp_q;
    rn_frac_w = rn_sum_w[22:0];
    if (rn_sum_w[24]) begin
      rn_exp_w  = nm_exp_q + 10'sd1;
      rn_frac_w = rn_sum_w[23:1];
    end
    if (al_spec_q)                round_res = al_spec_val_q;
    else if (nm_zero_q)           round_res = 32'h0;
    else if (rn_exp_w < 10'sd1)   round_res = {al_sign_q, 31'h0};
    else if (rn_exp_w >= 10'sd255) round_res = {al_sign_q, 8'hFF, 23'h0};
    else                          round_res = {al_sign_q, rn_exp_w[7:0], rn_frac_w};
  end

endmodule

// File: tb/tb_fp_accumulator.sv
// Directed bench for fp_accumulator: hand-computed group sums, cycle
// timing of each term, output backpressure and reset in mid-operation.
module tb_fp_accumulator;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  fp_accumulator_if bus ();

  fp_accumulator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one term; checks that the block stays busy (ignoring junk on the
  // bus) for edges N+1..N+3 and returns just after edge N+4, where either the
  // finished group is visible (last) or the block is ready again.
  task automatic send_term(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL send_wait_ready: in_ready=%b expected 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    @(posedge clk);
    #1;
    // junk held valid while busy must be ignored
    bus.in_data = 32'h7F80_0001;
    bus.in_last = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL busy_edge_%0d: in_ready=%b out_valid=%b expected 0 0",
                 k, bus.in_ready, bus.out_valid);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (l) begin
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL result_timing: out_valid=%b in_ready=%b expected 1 0",
                 bus.out_valid, bus.in_ready);
      end
    end else begin
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL ready_again: in_ready=%b out_valid=%b expected 1 0",
                 bus.in_ready, bus.out_valid);
      end
    end
  endtask

  // Check the presented sum, take it, and confirm the block returns to IDLE.
  task automatic take_result(input string nm, input logic [31:0] want);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== want) begin
      miscompares++;
      $display("FAIL %s: out_valid=%b out_data=%h expected 1 %h",
               nm, bus.out_valid, bus.out_data, want);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 32'h0) begin
      miscompares++;
      $display("FAIL %s_handoff: out_valid=%b in_ready=%b out_data=%h expected 0 1 00000000",
               nm, bus.out_valid, bus.in_ready, bus.out_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: in_ready=%b out_valid=%b out_data=%h expected 0 0 00000000",
               bus.in_ready, bus.out_valid, bus.out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: in_ready=%b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_add_basic();
    send_term(32'h3F80_0000, 1'b0);   // 1.0
    send_term(32'h4000_0000, 1'b1);   // + 2.0
    take_result("sum_1_plus_2", 32'h4040_0000);
  endtask

  task automatic test_cancel();
    send_term(32'h3F80_0000, 1'b0);
    send_term(32'hBF80_0000, 1'b1);
    take_result("exact_cancel", 32'h0000_0000);
  endtask

  task automatic test_round_tie();
    send_term(32'h3F80_0000, 1'b0);
    send_term(32'h3380_0000, 1'b1);   // half an ulp of 1.0: tie to even
    take_result("round_tie_even", 32'h3F80_0000);
  endtask

  task automatic test_round_sticky();
    send_term(32'h3F80_0000, 1'b0);
    send_term(32'h3380_0001, 1'b1);   // just over half an ulp
    take_result("round_sticky_up", 32'h3F80_0001);
  endtask

  task automatic test_overflow();
    send_term(32'h7F7F_FFFF, 1'b0);
    send_term(32'h7F7F_FFFF, 1'b1);
    take_result("overflow_inf", 32'h7F80_0000);
  endtask

  task automatic test_inf_nan();
    send_term(32'h7F80_0000, 1'b0);
    send_term(32'hFF80_0000, 1'b1);
    take_result("inf_minus_inf", 32'h7FC0_0000);
    // a NaN term poisons the rest of its group
    send_term(32'h7FC0_1234, 1'b0);
    send_term(32'h3F80_0000, 1'b1);
    take_result("nan_persists", 32'h7FC0_0000);
    // denormal term is flushed, negative result keeps its sign
    send_term(32'h0000_0005, 1'b0);
    send_term(32'hC0A0_0000, 1'b1);   // -5.0
    take_result("denorm_flush", 32'hC0A0_0000);
  endtask

  task automatic test_backpressure();
    send_term(32'h3F80_0000, 1'b0);
    send_term(32'h4000_0000, 1'b1);
    bus.in_valid = 1'b1;              // offered term must be ignored while in OUT
    bus.in_data  = 32'h4120_0000;
    bus.in_last  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h4040_0000 || bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL backpressure_hold_%0d: out_valid=%b out_data=%h in_ready=%b expected 1 40400000 0",
                 k, bus.out_valid, bus.out_data, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    take_result("backpressure_sum", 32'h4040_0000);
    send_term(32'h4040_0000, 1'b1);
    take_result("restart_from_zero", 32'h4040_0000);
  endtask

  task automatic test_mid_reset();
    send_term(32'h4000_0000, 1'b0);   // acc = 2.0, group still open
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h4000_0000;
    bus.in_last  = 1'b1;
    @(posedge clk);                   // transfer: now ALIGN
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);                   // now ADD
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: in_ready=%b out_valid=%b out_data=%h expected 0 0 00000000",
               bus.in_ready, bus.out_valid, bus.out_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_no_output: out_valid=%b in_ready=%b expected 0 1",
               bus.out_valid, bus.in_ready);
    end
    send_term(32'h3F80_0000, 1'b1);
    take_result("after_mid_reset", 32'h3F80_0000);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'h0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    test_reset();
    test_add_basic();
    test_cancel();
    test_round_tie();
    test_round_sticky();
    test_overflow();
    test_inf_nan();
    test_backpressure();
    test_mid_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_accumulator.md
FP_ACCUMULATOR -- requirements
Module: fp_accumulator

Interface
Parameters: none.
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with these ports:
  - clk  input  1  rising-edge clock
  - rst  input  1  asynchronous active-high reset
  - in_valid  input  1  term on in_data is valid
  - in_ready  output  1  block can accept a term
  - in_data  input  32  IEEE-754 single term (product from the multiplier stage)
  - in_last  input  1  term is the final term of the current group
  - out_valid  output  1  out_data holds a completed group sum
  - out_ready  input  1  consumer accepts out_data
  - out_data  output  32  IEEE-754 single group sum

Function
REQ-002 The block SHALL sum each group of terms, in arrival order, into a 32-bit accumulator acc that starts each group at +0 (0x00000000).
REQ-003 A term SHALL transfer only on a rising edge with in_valid=1 and in_ready=1; in_ready SHALL be 1 only in state IDLE.
REQ-004 The FSM SHALL have states IDLE, ALIGN, ADD, NORM, ROUND, OUT, each lasting exactly one cycle except IDLE and OUT.
REQ-005 Transitions:
  - IDLE->ALIGN on transfer; in_data and in_last are captured.
  - ALIGN->ADD->NORM->ROUND unconditionally.
  - ROUND->OUT if the captured last flag is 1, else ROUND->IDLE.
  - OUT->IDLE on out_valid=1 and out_ready=1.
REQ-006 Timing: a term transferred at edge N SHALL update acc at edge N+4; for a last term, out_valid SHALL be 1 from cycle N+5.
REQ-007 Throughput SHALL be at most one term per 5 cycles.
REQ-008 In OUT: out_valid=1; out_data=acc, stable until the handshake; in_ready=0.
REQ-009 On the OUT handshake, acc SHALL clear to +0. out_valid SHALL be 0 in every other state.
REQ-010 ALIGN:
  - Unpack both operands to {sign, exp[7:0], 1.mant[22:0]}.
  - Swap so that the operand with the larger magnitude is first.
  - Right-shift the smaller significand by the exponent difference into a 27-bit field (24 significand bits + guard + round + sticky).
  - Fold all shifted-out bits into sticky.
  - A difference of 26 or more SHALL leave only sticky set.
REQ-011 ADD SHALL add the significands if the signs are equal, else subtract the smaller from the larger; the result sign is that of the larger operand.
REQ-012 NORM:
  - On carry-out, shift right 1 and increment the exponent.
  - Otherwise left-shift until the MSB is set (leading-zero count), decrementing the exponent.
REQ-013 ROUND SHALL round to nearest, ties to even, using guard, round and sticky. A rounding carry SHALL renormalise and increment the exponent.
REQ-014 Inputs with exp=0 SHALL be treated as signed zero (denormals flushed).
REQ-015 A result exponent below 1 SHALL flush to zero with the result sign.
REQ-016 Exact cancellation SHALL give +0.
REQ-017 A result exponent at or above 255 SHALL give signed infinity (exp=255, mant=0).
REQ-018 Infinity inputs (exp=255, mant=0) SHALL propagate as infinity.
REQ-019 Opposite-signed infinities, or any NaN input, SHALL give the canonical NaN 0x7FC00000, which persists until the group ends.
REQ-020 in_data and in_last SHALL be ignored whenever in_ready=0.

Reset
REQ-021 While rst=1, asynchronously, the block SHALL force:
  - state=IDLE
  - acc=0x00000000
  - in_ready=0, out_valid=0, out_data=0x00000000
  - captured term and flags cleared
REQ-022 in_ready SHALL rise in the first cycle after rst deasserts.
REQ-023 A reset during any state, including ALIGN..ROUND or OUT, SHALL discard the partial group with no output produced.

Verification
REQ-024 Group 0x3F800000, then 0x40000000 with last -> out_data 0x40400000; out_valid exactly 5 cycles after the second transfer.
REQ-025 Group 0x3F800000, then 0xBF800000 with last -> out_data 0x00000000.
REQ-026 Group 0x3F800000 + 0x33800000 (tie) -> 0x3F800000.
REQ-027 Group 0x3F800000 + 0x33800001 -> 0x3F800001.
REQ-028 Group 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
REQ-029 Group 0x7F800000 + 0xFF800000 -> 0x7FC00000.
REQ-030 Backpressure: hold out_ready=0 for 10 cycles -> out_valid=1, out_data stable and in_ready=0 throughout. After the handshake, a single term 0x40400000 with last -> 0x40400000 (acc restarted from +0).
REQ-031 Mid-operation reset: assert rst in ADD -> the same cycle shows in_ready=0, out_valid=0 and out_data=0. After release, a single term 0x3F800000 with last -> 0x3F800000.
